// File: rtl/psram_port_arbiter.sv
// Round-robin arbiter sharing one PSRAM/HyperRAM phy command/data channel between N requesters.
// A grant covers a whole transaction; a progress watchdog aborts stalled transfers.
module psram_port_arbiter #(
   parameter int N       = 3,
   parameter int AW      = 24,
   parameter int DW      = 16,
   parameter int LW      = 6,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N-1:0]          req_cmd_valid,
   output logic [N-1:0]          req_cmd_ready,
   input  logic [N-1:0]          req_cmd_write,
   input  logic [N*AW-1:0]       req_cmd_addr,
   input  logic [N*LW-1:0]       req_cmd_len,
   input  logic [N-1:0]          req_wdata_valid,
   output logic [N-1:0]          req_wdata_ready,
   input  logic [N*DW-1:0]       req_wdata,
   input  logic [N*DW/8-1:0]     req_wmask,
   output logic [N-1:0]          req_rsp_valid,
   output logic [DW-1:0]         req_rsp_data,
   output logic                  mem_cmd_valid,
   input  logic                  mem_cmd_ready,
   output logic                  mem_cmd_write,
   output logic [AW-1:0]         mem_cmd_addr,
   output logic [LW-1:0]         mem_cmd_len,
   output logic                  mem_wdata_valid,
   input  logic                  mem_wdata_ready,
   output logic [DW-1:0]         mem_wdata,
   output logic [DW/8-1:0]       mem_wmask,
   input  logic                  mem_rsp_valid,
   input  logic [DW-1:0]         mem_rsp_data,
   output logic [$clog2(N)-1:0]  grant_id,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_stray_rsp
);

   localparam int GW  = $clog2(N);
   localparam int MW  = DW / 8;
   localparam int WDW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_q, last_d;
   logic            write_q, write_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [WDW-1:0]  wdog_q, wdog_d;
   logic            err_timeout_q, err_timeout_d;
   logic            err_stray_q, err_stray_d;

   logic            pick_found;
   logic [GW-1:0]   pick_idx;
   logic [GW-1:0]   cand;
   logic            hs;

   // Search upward from the requester after the last winner, wrapping modulo N.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 1; k <= N; k++) begin
         cand = GW'((int'(last_q) + k) % N);
         if (!pick_found && req_cmd_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d         = state_q;
      grant_d         = grant_q;
      last_d          = last_q;
      write_d         = write_q;
      len_d           = len_q;
      cnt_d           = cnt_q;
      wdog_d          = '0;
      err_timeout_d   = err_timeout_q;
      err_stray_d     = err_stray_q | (mem_rsp_valid && (state_q != RDATA));
      hs              = 1'b0;
      req_cmd_ready   = '0;
      req_wdata_ready = '0;
      req_rsp_valid   = '0;
      req_rsp_data    = '0;
      mem_cmd_valid   = 1'b0;
      mem_cmd_write   = 1'b0;
      mem_cmd_addr    = '0;
      mem_cmd_len     = '0;
      mem_wdata_valid = 1'b0;
      mem_wdata       = '0;
      mem_wmask       = '0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick_idx;
               write_d = req_cmd_write[pick_idx];
               len_d   = req_cmd_len[pick_idx*LW +: LW];
               state_d = CMD;
            end
         end
         CMD: begin
            mem_cmd_valid          = req_cmd_valid[grant_q];
            mem_cmd_write          = req_cmd_write[grant_q];
            mem_cmd_addr           = req_cmd_addr[grant_q*AW +: AW];
            mem_cmd_len            = req_cmd_len[grant_q*LW +: LW];
            req_cmd_ready[grant_q] = mem_cmd_ready;
            if (!req_cmd_valid[grant_q]) begin
               state_d = IDLE;
            end else if (mem_cmd_ready) begin
               hs      = 1'b1;
               cnt_d   = len_q;
               last_d  = grant_q;
               state_d = write_q ? WDATA : RDATA;
            end
         end
         WDATA: begin
            mem_wdata_valid          = req_wdata_valid[grant_q];
            mem_wdata                = req_wdata[grant_q*DW +: DW];
            mem_wmask                = req_wmask[grant_q*MW +: MW];
            req_wdata_ready[grant_q] = mem_wdata_ready;
            if (req_wdata_valid[grant_q] && mem_wdata_ready) begin
               hs = 1'b1;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - LW'(1);
            end
         end
         RDATA: begin
            req_rsp_valid[grant_q] = mem_rsp_valid;
            req_rsp_data           = mem_rsp_data;
            if (mem_rsp_valid) begin
               hs = 1'b1;
               if (cnt_q == '0) state_d = IDLE;
               else             cnt_d   = cnt_q - LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Watchdog: the TIMEOUT-th consecutive cycle without a handshake aborts the transaction.
      if (state_q != IDLE && !hs) begin
         if (wdog_q == WDW'(TIMEOUT - 1)) begin
            err_timeout_d = 1'b1;
            state_d       = IDLE;
         end else begin
            wdog_d = wdog_q + WDW'(1);
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         last_q        <= GW'(N - 1);
         write_q       <= 1'b0;
         len_q         <= '0;
         cnt_q         <= '0;
         wdog_q        <= '0;
         err_timeout_q <= 1'b0;
         err_stray_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         write_q       <= write_d;
         len_q         <= len_d;
         cnt_q         <= cnt_d;
         wdog_q        <= wdog_d;
         err_timeout_q <= err_timeout_d;
         err_stray_q   <= err_stray_d;
      end
   end

   assign grant_id      = grant_q;
   assign busy          = (state_q != IDLE);
   assign err_timeout   = err_timeout_q;
   assign err_stray_rsp = err_stray_q;

endmodule

// File: tb/tb_psram_port_arbiter.sv
// Scoreboard bench for psram_port_arbiter: expected cmd/write/read beats are queued as stimulus
// is driven and popped when the DUT shows the matching handshake.
module tb_psram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int LW = 6;
   localparam int TO = 16;
   localparam int MW = DW / 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_cmd_valid, req_cmd_ready, req_cmd_write;
   logic [N*AW-1:0]   req_cmd_addr;
   logic [N*LW-1:0]   req_cmd_len;
   logic [N-1:0]      req_wdata_valid, req_wdata_ready;
   logic [N*DW-1:0]   req_wdata;
   logic [N*MW-1:0]   req_wmask;
   logic [N-1:0]      req_rsp_valid;
   logic [DW-1:0]     req_rsp_data;
   logic              mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
   logic [AW-1:0]     mem_cmd_addr;
   logic [LW-1:0]     mem_cmd_len;
   logic              mem_wdata_valid, mem_wdata_ready;
   logic [DW-1:0]     mem_wdata;
   logic [MW-1:0]     mem_wmask;
   logic              mem_rsp_valid;
   logic [DW-1:0]     mem_rsp_data;
   logic [1:0]        grant_id;
   logic              busy, err_timeout, err_stray_rsp;

   psram_port_arbiter #(.N(N), .AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready),
      .req_cmd_write(req_cmd_write), .req_cmd_addr(req_cmd_addr), .req_cmd_len(req_cmd_len),
      .req_wdata_valid(req_wdata_valid), .req_wdata_ready(req_wdata_ready),
      .req_wdata(req_wdata), .req_wmask(req_wmask),
      .req_rsp_valid(req_rsp_valid), .req_rsp_data(req_rsp_data),
      .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
      .mem_cmd_addr(mem_cmd_addr), .mem_cmd_len(mem_cmd_len),
      .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_stray_rsp(err_stray_rsp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [63:0] exp_cmd_q[$];
   logic [63:0] exp_wr_q[$];
   logic [63:0] exp_rsp_q[$];

   logic        hs_cmd, hs_wr;
   logic [1:0]  hs_gnt;
   logic [N-1:0] wready_snap;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] cmd_word(input logic [1:0] g, input logic w,
                                            input logic [AW-1:0] a, input logic [LW-1:0] l);
      return {31'b0, g, w, a, l};
   endfunction

   function automatic logic [63:0] wr_word(input logic [MW-1:0] m, input logic [DW-1:0] d);
      return {46'b0, m, d};
   endfunction

   function automatic logic [63:0] rsp_word(input logic [N-1:0] v, input logic [DW-1:0] d);
      return {45'b0, v, d};
   endfunction

   task automatic clear_inputs();
      req_cmd_valid = '0; req_cmd_write = '0; req_cmd_addr = '0; req_cmd_len = '0;
      req_wdata_valid = '0; req_wdata = '0; req_wmask = '0;
      mem_cmd_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_cmd_q.delete(); exp_wr_q.delete(); exp_rsp_q.delete();
   endtask

   task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_cmd_valid[i]          = 1'b1;
      req_cmd_write[i]          = w;
      req_cmd_addr[i*AW +: AW]  = a;
      req_cmd_len[i*LW +: LW]   = l;
   endtask

   // One cycle: observe handshakes just before the rising edge, score them, advance to next negedge.
   task automatic step();
      #1;
      hs_cmd      = mem_cmd_valid && mem_cmd_ready;
      hs_wr       = mem_wdata_valid && mem_wdata_ready;
      hs_gnt      = grant_id;
      wready_snap = req_wdata_ready;
      if (hs_cmd) begin
         if (exp_cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
         else check("cmd", cmd_word(hs_gnt, mem_cmd_write, mem_cmd_addr, mem_cmd_len), exp_cmd_q.pop_front());
      end
      if (hs_wr) begin
         if (exp_wr_q.size() == 0) check("wr_unexpected", 1, 0);
         else check("wr_beat", wr_word(mem_wmask, mem_wdata), exp_wr_q.pop_front());
      end
      if (|req_rsp_valid) begin
         if (exp_rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
         else check("rsp_beat", rsp_word(req_rsp_valid, req_rsp_data), exp_rsp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic wait_cmd_hs(input string tag);
      for (int c = 0; c < 20; c++) begin
         step();
         if (hs_cmd) break;
      end
      check(tag, hs_cmd, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pending[N];
      int wpend[N];
      int round[N];
      int last_hs, n_done, beat;
      logic cmd_done, tog;

      // ---------------- reset values and single read ----------------
      reset_dut();
      #1;
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_cmd_valid", mem_cmd_valid, 0);
      check("rst_ready", {req_cmd_ready, req_wdata_ready, req_rsp_valid}, 0);
      check("rst_errs", {err_timeout, err_stray_rsp}, 0);
      @(negedge clk);

      set_cmd(1, 1'b0, 24'h000100, 6'd3);
      exp_cmd_q.push_back(cmd_word(2'd1, 1'b0, 24'h000100, 6'd3));
      #1 check("t1_cmd_valid_t0", mem_cmd_valid, 0);
      step();
      check("t1_cmd_valid_t1", mem_cmd_valid, 1);
      check("t1_grant", grant_id, 1);
      mem_cmd_ready = 1'b1;
      step();
      check("t1_cmd_hs", hs_cmd, 1);
      req_cmd_valid = '0;
      mem_cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 16'(16'hA0 + i);
         exp_rsp_q.push_back(rsp_word(3'b010, 16'(16'hA0 + i)));
         step();
      end
      mem_rsp_valid = 1'b0;
      #1;
      check("t1_busy_done", busy, 0);
      check("t1_rsp_left", exp_rsp_q.size(), 0);
      @(negedge clk);

      // ---------------- contention: three writers, two rounds ----------------
      reset_dut();
      mem_cmd_ready   = 1'b1;
      mem_wdata_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         pending[i] = 1; wpend[i] = 0; round[i] = 0;
         req_cmd_write[i]          = 1'b1;
         req_cmd_addr[i*AW +: AW]  = 24'(24'h4000 + i * 24'h100);
         req_cmd_len[i*LW +: LW]   = '0;
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++)
            exp_cmd_q.push_back(cmd_word(2'(i), 1'b1, 24'(24'h4000 + i * 24'h100), 6'd0));
      last_hs = -1;
      n_done  = 0;
      for (int c = 0; c < 100 && n_done < 6; c++) begin
         for (int i = 0; i < N; i++) begin
            req_cmd_valid[i]          = (pending[i] != 0);
            req_wdata_valid[i]        = (wpend[i] != 0);
            req_wdata[i*DW +: DW]     = 16'(16'hC000 + i * 16 + round[i]);
            req_wmask[i*MW +: MW]     = 2'(i + 1);
         end
         step();
         if (hs_cmd) begin
            if (last_hs >= 0) check("t2_gap", cyc - last_hs, 3);
            last_hs = cyc;
            pending[hs_gnt] = 0;
            wpend[hs_gnt]   = 1;
            exp_wr_q.push_back(wr_word(2'(hs_gnt + 1), 16'(16'hC000 + hs_gnt * 16 + round[hs_gnt])));
         end
         if (hs_wr) begin
            wpend[hs_gnt] = 0;
            round[hs_gnt]++;
            n_done++;
            if (round[hs_gnt] < 2) pending[hs_gnt] = 1;
         end
      end
      check("t2_done", n_done, 6);
      check("t2_cmd_left", exp_cmd_q.size(), 0);
      check("t2_wr_left", exp_wr_q.size(), 0);
      clear_inputs();
      @(negedge clk);

      // ---------------- write with backpressure ----------------
      reset_dut();
      set_cmd(2, 1'b1, 24'h002000, 6'd7);
      exp_cmd_q.push_back(cmd_word(2'd2, 1'b1, 24'h002000, 6'd7));
      for (int k = 0; k < 8; k++) exp_wr_q.push_back(wr_word(2'(k), 16'(16'h1111 * (k + 1))));
      mem_cmd_ready = 1'b1;
      beat = 0; cmd_done = 1'b0; tog = 1'b0;
      for (int c = 0; c < 100 && beat < 8; c++) begin
         req_cmd_valid[2]       = !cmd_done;
         req_wdata_valid[2]     = cmd_done;
         req_wdata[2*DW +: DW]  = 16'(16'h1111 * (beat + 1));
         req_wmask[2*MW +: MW]  = 2'(beat);
         mem_wdata_ready        = tog;
         tog                    = ~tog;
         step();
         check("t3_other_ready", wready_snap[1:0], 0);
         if (hs_cmd) cmd_done = 1'b1;
         if (hs_wr) beat++;
      end
      clear_inputs();
      #1;
      check("t3_beats", beat, 8);
      check("t3_busy_done", busy, 0);
      check("t3_wr_left", exp_wr_q.size(), 0);
      @(negedge clk);

      // ---------------- maximum burst read, then a stray beat ----------------
      reset_dut();
      set_cmd(0, 1'b0, 24'h010000, 6'd63);
      exp_cmd_q.push_back(cmd_word(2'd0, 1'b0, 24'h010000, 6'd63));
      mem_cmd_ready = 1'b1;
      wait_cmd_hs("t4_cmd_hs");
      req_cmd_valid = '0;
      mem_cmd_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 16'(16'h5000 + i);
         exp_rsp_q.push_back(rsp_word(3'b001, 16'(16'h5000 + i)));
         step();
      end
      mem_rsp_valid = 1'b0;
      #1;
      check("t4_busy_done", busy, 0);
      check("t4_stray_before", err_stray_rsp, 0);
      check("t4_rsp_left", exp_rsp_q.size(), 0);
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'hDEAD;
      #1 check("t4_stray_routed", req_rsp_valid, 0);
      step();
      mem_rsp_valid = 1'b0;
      check("t4_stray_set", err_stray_rsp, 1);
      repeat (3) step();
      check("t4_stray_sticky", err_stray_rsp, 1);

      // ---------------- watchdog timeout ----------------
      reset_dut();
      set_cmd(1, 1'b0, 24'h000300, 6'd1);
      exp_cmd_q.push_back(cmd_word(2'd1, 1'b0, 24'h000300, 6'd1));
      mem_cmd_ready = 1'b1;
      wait_cmd_hs("t5_cmd_hs");
      req_cmd_valid = '0;
      mem_cmd_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'h7777;
      exp_rsp_q.push_back(rsp_word(3'b010, 16'h7777));
      step();
      mem_rsp_valid = 1'b0;
      repeat (TO - 1) step();
      check("t5_no_timeout_yet", err_timeout, 0);
      check("t5_busy_before", busy, 1);
      step();
      check("t5_timeout", err_timeout, 1);
      check("t5_idle", busy, 0);
      check("t5_outputs_off", {req_rsp_valid, mem_cmd_valid, mem_wdata_valid}, 0);
      set_cmd(2, 1'b0, 24'h000400, 6'd0);
      exp_cmd_q.push_back(cmd_word(2'd2, 1'b0, 24'h000400, 6'd0));
      mem_cmd_ready = 1'b1;
      wait_cmd_hs("t5_next_cmd_hs");
      req_cmd_valid = '0;
      mem_cmd_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'h8888;
      exp_rsp_q.push_back(rsp_word(3'b100, 16'h8888));
      step();
      mem_rsp_valid = 1'b0;
      check("t5_next_done", busy, 0);
      check("t5_rsp_left", exp_rsp_q.size(), 0);
      check("t5_timeout_sticky", err_timeout, 1);

      // ---------------- reset in the middle of a write burst ----------------
      reset_dut();
      set_cmd(2, 1'b1, 24'h000500, 6'd7);
      exp_cmd_q.push_back(cmd_word(2'd2, 1'b1, 24'h000500, 6'd7));
      mem_cmd_ready = 1'b1;
      wait_cmd_hs("t6_cmd_hs");
      req_cmd_valid   = '0;
      mem_cmd_ready   = 1'b0;
      mem_wdata_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req_wdata_valid[2]    = 1'b1;
         req_wdata[2*DW +: DW] = 16'(16'h0100 * (k + 1));
         req_wmask[2*MW +: MW] = 2'b11;
         exp_wr_q.push_back(wr_word(2'b11, 16'(16'h0100 * (k + 1))));
         step();
      end
      req_wdata[2*DW +: DW] = 16'h0300;
      #1 check("t6_beat3_active", mem_wdata_valid, 1);
      #1 reset = 1'b1;
      #1;
      check("t6_rst_wvalid", mem_wdata_valid, 0);
      check("t6_rst_wready", req_wdata_ready, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_grant", grant_id, 0);
      check("t6_rst_wdata", {mem_wdata, mem_wmask, mem_cmd_valid, req_rsp_valid}, 0);
      clear_inputs();
      exp_wr_q.delete();
      @(negedge clk);
      reset = 1'b0;
      set_cmd(1, 1'b0, 24'h000600, 6'd0);
      set_cmd(0, 1'b0, 24'h000700, 6'd0);
      exp_cmd_q.push_back(cmd_word(2'd0, 1'b0, 24'h000700, 6'd0));
      step();
      check("t6_first_grant", grant_id, 0);
      mem_cmd_ready = 1'b1;
      step();
      check("t6_cmd_hs", hs_cmd, 1);
      clear_inputs();
      check("t6_cmd_left", exp_cmd_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/psram_port_arbiter.md
Name: psram_port_arbiter

Overview:
- Round-robin arbiter that shares the single 16-bit PSRAM/HyperRAM phy command and data channel between N bus requesters (CPU data bus, instruction fetch, DMA).
- A grant is held for one whole transaction: the command, all write beats or all read beats.
- Routes read data back to the owning requester.
- Includes a progress watchdog that aborts a stalled transaction and reports it through sticky error flags.
- Sits between the SoC interconnect and the phy controller inside SpinexWithClock.

Parameters:
- N, 3, number of requesters (2..8)
- AW, 24, byte address width
- DW, 16, data width; matches the phy DQ width
- LW, 6, burst length field width; len encodes beats-1, so 1..2^LW beats
- TIMEOUT, 1024, cycles without a handshake before a data phase is aborted

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_cmd_valid  in  N  command request per requester
- req_cmd_ready  out  N  command accepted
- req_cmd_write  in  N  1=write, 0=read
- req_cmd_addr  in  N*AW  flattened addresses; requester i uses bits [i*AW +: AW]
- req_cmd_len  in  N*LW  flattened beats-1
- req_wdata_valid  in  N  write beat valid
- req_wdata_ready  out  N  write beat accepted
- req_wdata  in  N*DW  flattened write data
- req_wmask  in  N*DW/8  flattened byte enables
- req_rsp_valid  out  N  read beat valid for requester i
- req_rsp_data  out  DW  read data, shared by all requesters
- mem_cmd_valid  out  1  command to the phy controller
- mem_cmd_ready  in  1  phy accepts command
- mem_cmd_write  out  1
- mem_cmd_addr  out  AW
- mem_cmd_len  out  LW
- mem_wdata_valid  out  1
- mem_wdata_ready  in  1
- mem_wdata  out  DW
- mem_wmask  out  DW/8
- mem_rsp_valid  in  1  read beat from the phy
- mem_rsp_data  in  DW
- grant_id  out  clog2(N)  current owner
- busy  out  1  state != IDLE
- err_timeout  out  1  sticky; cleared only by reset
- err_stray_rsp  out  1  sticky; cleared only by reset

Behaviour:
- Reset values: all valid/ready outputs 0, grant_id 0, busy 0, err flags 0, round-robin pointer last=N-1 (requester 0 has top priority first), FSM in IDLE.
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE:
  - If any req_cmd_valid is set, pick the first set bit searching upward from last+1, modulo N.
  - Register that requester as grant_id and latch its write and len fields; go to CMD next cycle.
  - Arbitration latency: request in cycle t, mem_cmd_valid in cycle t+1.
- CMD:
  - mem_cmd_* are driven combinationally from the granted requester's fields.
  - req_cmd_ready[grant] = mem_cmd_ready; all other req_cmd_ready bits are 0.
  - On the handshake: load the beat counter with len, set last=grant, go to WDATA if write else RDATA.
  - The requester must hold valid and fields stable until ready. If it drops valid before the handshake, abandon the command and return to IDLE; last is unchanged.
- WDATA:
  - Pass-through: mem_wdata_valid = req_wdata_valid[grant]; req_wdata_ready[grant] = mem_wdata_ready; data and mask are muxed from the owner.
  - Each handshake decrements the counter. The handshake with counter==0 is the final beat: go to IDLE.
- RDATA:
  - req_rsp_valid[grant] = mem_rsp_valid; req_rsp_data = mem_rsp_data (zero added latency, no backpressure).
  - Each beat decrements the counter. The beat at counter==0 is the final beat: go to IDLE.
- Back-to-back transactions: one IDLE cycle is always inserted between them (a fixed bubble).
- Watchdog:
  - The counter resets on every cmd, wdata or rsp handshake and on entry to CMD.
  - In CMD, WDATA or RDATA, reaching TIMEOUT with no handshake sets err_timeout and forces IDLE. All outputs deassert the same cycle as the IDLE transition.
- mem_rsp_valid while not in RDATA: ignore the beat, route it to nobody, set err_stray_rsp.
- Simultaneous requests: strictly round-robin. A requester granted in one transaction has the lowest priority in the next arbitration.
- Reset asserted mid-transaction: FSM returns to IDLE asynchronously and all outputs go to their reset values. The phy controller is reset by the same signal.
- Counter width is LW. Maximum len (2^LW-1) produces exactly 2^LW beats; the counter never wraps.

Test Plan:
- Single read: req1 read, addr 0x000100, len 3; phy returns 0xA0..0xA3. Required: mem_cmd_valid 1 cycle after req; req_rsp_valid[1] pulses 4 times with 0xA0..0xA3; busy clears after the 4th beat.
- Contention: req0, req1 and req2 all assert write len 0 on the same cycle. Required: grant order 0,1,2, then again 0,1,2 when they re-request; each transaction is separated by exactly 1 IDLE cycle.
- Write with backpressure: req2 write len 7, data 0x1111..0x8888; mem_wdata_ready toggles every cycle. Required: exactly 8 beats in order, masks passed through unchanged, other requesters never see ready.
- Max burst: len=63 read. Required: 64 rsp beats, then IDLE; a 65th mem_rsp_valid sets err_stray_rsp.
- Timeout: read len 1, phy sends 1 beat and then stops; TIMEOUT=16. Required: err_timeout=1 16 cycles after the last beat, FSM returns to IDLE, and the next request is serviced normally.
- Reset mid-burst: assert reset during WDATA beat 3 of 8. Required: all outputs 0 immediately, grant_id 0, and the first grant after reset goes to requester 0.
